obi_mux: RTL

- N-to-1 OBI multiplexer: the counterpart of the 1-to-N OBI demux.
- Arbitrates requests from NumSlvPorts initiator-side (slave) ports onto one target-side (master) port.
- Routes each response back to the port that issued the request, strictly in issue order.
- Sits in front of shared OBI targets (memories, peripheral buses) that several OBI managers access.

---
 rtl/obi_mux.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/obi_mux.sv
// N-to-1 OBI multiplexer: arbitrates manager requests onto one target and routes responses back in issue order.
// Define OBI_MUX_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
// Packed channel layouts: request = {req, a, rready}, response = {gnt, rvalid, r}.
module obi_mux #(
   parameter int unsigned NumSlvPorts = 32'd2,
   parameter int unsigned NumMaxTrans = 32'd2,
   parameter int unsigned AWidth      = 32'd32,
   parameter int unsigned RWidth      = 32'd32,
   parameter bit          UseRReady   = 1'b0,
   parameter bit          Integrity   = 1'b0,
   parameter int unsigned IdxWidth    = (NumSlvPorts > 32'd1) ? $clog2(NumSlvPorts) : 32'd1,
   localparam int unsigned ReqWidth   = AWidth + 32'd2,
   localparam int unsigned RspWidth   = RWidth + 32'd2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NumSlvPorts-1:0][ReqWidth-1:0] slv_ports_req_i,
   output logic [NumSlvPorts-1:0][RspWidth-1:0] slv_ports_rsp_o,
   output logic [ReqWidth-1:0]                  mst_port_req_o,
   input  logic [RspWidth-1:0]                  mst_port_rsp_i
);

   localparam int unsigned PtrWidth = (NumMaxTrans > 32'd1) ? $clog2(NumMaxTrans) : 32'd1;
   localparam int unsigned CntWidth = $clog2(NumMaxTrans + 32'd1);

   if (Integrity) begin : gen_integrity_check
      $fatal(1, "obi_mux: integrity signals are not supported");
   end
   if (NumSlvPorts < 32'd2) begin : gen_ports_check
      $fatal(1, "obi_mux: NumSlvPorts must be at least 2");
   end
   if (NumMaxTrans < 32'd1) begin : gen_trans_check
      $fatal(1, "obi_mux: NumMaxTrans must be at least 1");
   end

   logic [NumSlvPorts-1:0]             slv_req;
   logic [NumSlvPorts-1:0]             slv_rready;
   logic [NumSlvPorts-1:0][AWidth-1:0] slv_a;
   logic [NumSlvPorts-1:0]             slv_gnt;
   logic [NumSlvPorts-1:0]             slv_rvalid;

   logic              mst_gnt;
   logic              mst_rvalid;
   logic [RWidth-1:0] mst_r;
   logic              mst_req;
   logic [AWidth-1:0] mst_a;
   logic              mst_rready;

   logic [IdxWidth-1:0] arb_idx;
   logic                arb_valid;
   logic [IdxWidth-1:0] sel_idx;
   logic                sel_valid;
   logic                handshake;

   logic                lock_q;
   logic [IdxWidth-1:0] lock_idx_q;

   logic [IdxWidth-1:0] fifo_mem [NumMaxTrans];
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [PtrWidth-1:0] wr_ptr_next;
   logic [PtrWidth-1:0] rd_ptr_next;
   logic [CntWidth-1:0] count_q;
   logic                fifo_empty;
   logic                fifo_full;
   logic [IdxWidth-1:0] head_idx;
   logic                rready_eff;
   logic                push;
   logic                pop;

   for (genvar i = 0; i < NumSlvPorts; i++) begin : gen_unpack
      assign slv_req[i]    = slv_ports_req_i[i][ReqWidth-1];
      assign slv_a[i]      = slv_ports_req_i[i][AWidth:1];
      assign slv_rready[i] = slv_ports_req_i[i][0];
   end

   assign mst_gnt    = mst_port_rsp_i[RspWidth-1];
   assign mst_rvalid = mst_port_rsp_i[RspWidth-2];
   assign mst_r      = mst_port_rsp_i[RWidth-1:0];

`ifdef OBI_MUX_FIXED_PRIO_EN
   // Scan from the top down so the lowest requesting index is written last and wins.
   always_comb begin
      arb_idx   = '0;
      arb_valid = 1'b0;
      for (int i = int'(NumSlvPorts) - 1; i >= 0; i--) begin
         if (slv_req[i]) begin
            arb_idx   = IdxWidth'(i);
            arb_valid = 1'b1;
         end
      end
   end
`else
   logic [IdxWidth-1:0] rr_q;

   // Candidates are visited from lowest to highest priority, so the last hit is the winner.
   always_comb begin
      int cand;
      cand      = 0;
      arb_idx   = '0;
      arb_valid = 1'b0;
      for (int i = int'(NumSlvPorts) - 1; i >= 0; i--) begin
         cand = int'(rr_q) + i;
         if (cand >= int'(NumSlvPorts)) begin
            cand = cand - int'(NumSlvPorts);
         end
         if (slv_req[cand]) begin
            arb_idx   = IdxWidth'(cand);
            arb_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q <= '0;
      end else if (handshake) begin
         rr_q <= (sel_idx == IdxWidth'(NumSlvPorts - 32'd1)) ? '0 : sel_idx + 1'b1;
      end
   end
`endif

   // A request stalled by the target keeps its port selected until it is granted.
   always_comb begin
      if (lock_q) begin
         sel_idx   = lock_idx_q;
         sel_valid = slv_req[lock_idx_q];
      end else begin
         sel_idx   = arb_idx;
         sel_valid = arb_valid;
      end
   end

   assign mst_req   = sel_valid && !fifo_full && !rst_i;
   assign mst_a     = sel_valid ? slv_a[sel_idx] : '0;
   assign handshake = mst_req && mst_gnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (mst_req && !mst_gnt) begin
         lock_q     <= 1'b1;
         lock_idx_q <= sel_idx;
      end else if (handshake) begin
         lock_q     <= 1'b0;
      end
   end

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == CntWidth'(NumMaxTrans));
   assign head_idx    = fifo_mem[rd_ptr_q];
   assign wr_ptr_next = (wr_ptr_q == PtrWidth'(NumMaxTrans - 32'd1)) ? '0 : wr_ptr_q + 1'b1;
   assign rd_ptr_next = (rd_ptr_q == PtrWidth'(NumMaxTrans - 32'd1)) ? '0 : rd_ptr_q + 1'b1;
   assign rready_eff  = UseRReady ? slv_rready[head_idx] : 1'b1;
   assign push        = handshake;
   assign pop         = mst_rvalid && !fifo_empty && rready_eff;

   // Routing storage needs no reset: entries are only read while count_q says they are valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= sel_idx;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_next;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_next;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign mst_rready = UseRReady ? (!fifo_empty && slv_rready[head_idx]) : 1'b1;

   for (genvar i = 0; i < NumSlvPorts; i++) begin : gen_rsp
      assign slv_gnt[i]         = handshake && (sel_idx == IdxWidth'(i));
      assign slv_rvalid[i]      = mst_rvalid && !fifo_empty && !rst_i && (head_idx == IdxWidth'(i));
      assign slv_ports_rsp_o[i] = {slv_gnt[i], slv_rvalid[i], mst_r};
   end

   assign mst_port_req_o = {mst_req, mst_a, mst_rready};

   // A response with nothing outstanding cannot be routed and is dropped.
   assert property (@(posedge clk_i) disable iff (rst_i) !(mst_rvalid && fifo_empty))
      else $warning("obi_mux: response with no outstanding transaction ignored");

endmodule
